// File: rtl/ddr_port0_arbiter_if.sv
// Port-0 command bus between the two pixel requesters and the MCB command FIFO.
// master: requester/MCB side, slave: the arbiter.
interface ddr_port0_arbiter_if;
  localparam int unsigned ADDR_W  = 30;
  localparam int unsigned BL_W    = 6;
  localparam int unsigned INSTR_W = 3;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [BL_W-1:0]   wr_bl;
  logic              wr_gnt;
  logic              wr_err;

  logic              rd_req;
  logic              rd_urgent;
  logic [ADDR_W-1:0] rd_addr;
  logic [BL_W-1:0]   rd_bl;
  logic              rd_gnt;
  logic              rd_err;

  logic               p0_cmd_full;
  logic               p0_cmd_en;
  logic [INSTR_W-1:0] p0_cmd_instr;
  logic [BL_W-1:0]    p0_cmd_bl;
  logic [ADDR_W-1:0]  p0_cmd_byte_addr;

  modport master (
    output wr_req, wr_addr, wr_bl, rd_req, rd_urgent, rd_addr, rd_bl, p0_cmd_full,
    input  wr_gnt, wr_err, rd_gnt, rd_err,
    input  p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr
  );

  modport slave (
    input  wr_req, wr_addr, wr_bl, rd_req, rd_urgent, rd_addr, rd_bl, p0_cmd_full,
    output wr_gnt, wr_err, rd_gnt, rd_err,
    output p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr
  );
endinterface

// File: rtl/ddr_port0_arbiter.sv
// MCB port-0 command arbiter: frame-store writer vs display fetcher, gated on calibration.
// Optional write-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module ddr_port0_arbiter #(
  parameter logic [29:0] ADDR_LIMIT = 30'd5242880
`ifdef ARB_STARVE_GUARD_EN
  , parameter int unsigned MAX_WAIT = 64
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_calib_done,
  ddr_port0_arbiter_if.slave      bus,
  output logic                    ready,
  output logic                    last_was_read
);

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned BL_W   = 6;

  localparam logic [1:0] CALIB = 2'd0;
  localparam logic [1:0] ARB   = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              calib_meta;
  logic              calib_sync;
  logic              rd_sel;
  logic              force_wr;
  logic              any_req;
  logic              addr_bad;
  logic [ADDR_W-1:0] win_addr;
  logic [BL_W-1:0]   win_bl;
  logic              issue_nxt;
  logic              wr_err_nxt;
  logic              rd_err_nxt;

  // Two-flop synchroniser for the asynchronous calibration flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calib_meta <= 1'b0;
      calib_sync <= 1'b0;
    end else begin
      calib_meta <= mem_calib_done;
      calib_sync <= calib_meta;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [6:0] starve_cnt;

  assign force_wr = bus.wr_req && (32'(starve_cnt) >= MAX_WAIT);

  // Counts ARB cycles in which a pending write loses to a read; cleared when the write is served
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 7'd0;
    end else if (state == ARB && any_req) begin
      if (!rd_sel && (addr_bad || !bus.p0_cmd_full)) begin
        starve_cnt <= 7'd0;
      end else if (rd_sel && bus.wr_req && starve_cnt != 7'h7f) begin
        starve_cnt <= starve_cnt + 7'd1;
      end
    end
  end
`else
  assign force_wr = 1'b0;
`endif

  // Winner selection: forced write, urgent read, round-robin, then the lone requester
  always_comb begin
    rd_sel = 1'b0;
    if (force_wr) begin
      rd_sel = 1'b0;
    end else if (bus.rd_req && bus.rd_urgent) begin
      rd_sel = 1'b1;
    end else if (bus.rd_req && bus.wr_req) begin
      rd_sel = ~last_was_read;
    end else begin
      rd_sel = bus.rd_req;
    end
  end

  assign any_req  = bus.wr_req | bus.rd_req;
  assign win_addr = rd_sel ? bus.rd_addr : bus.wr_addr;
  assign win_bl   = rd_sel ? bus.rd_bl : bus.wr_bl;
  assign addr_bad = (win_addr >= ADDR_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CALIB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue_nxt  = 1'b0;
    wr_err_nxt = 1'b0;
    rd_err_nxt = 1'b0;
    case (state)
      CALIB: if (calib_sync) state_nxt = ARB;
      ARB: begin
        if (any_req) begin
          if (addr_bad) begin
            wr_err_nxt = ~rd_sel;
            rd_err_nxt = rd_sel;
            state_nxt  = GAP;
          end else if (!bus.p0_cmd_full) begin
            issue_nxt = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE:   state_nxt = GAP;
      GAP:     state_nxt = ARB;
      default: state_nxt = CALIB;
    endcase
  end

  // Command fields are captured on the ARB->ISSUE edge so they are stable for the whole strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.p0_cmd_en        <= 1'b0;
      bus.p0_cmd_instr     <= 3'b000;
      bus.p0_cmd_bl        <= '0;
      bus.p0_cmd_byte_addr <= '0;
      bus.wr_gnt           <= 1'b0;
      bus.rd_gnt           <= 1'b0;
      bus.wr_err           <= 1'b0;
      bus.rd_err           <= 1'b0;
      ready                <= 1'b0;
      last_was_read        <= 1'b0;
    end else begin
      bus.p0_cmd_en <= issue_nxt;
      bus.wr_gnt    <= issue_nxt & ~rd_sel;
      bus.rd_gnt    <= issue_nxt & rd_sel;
      bus.wr_err    <= wr_err_nxt;
      bus.rd_err    <= rd_err_nxt;
      ready         <= (state_nxt != CALIB);
      if (issue_nxt) begin
        bus.p0_cmd_instr     <= rd_sel ? 3'b001 : 3'b000;
        bus.p0_cmd_bl        <= win_bl;
        bus.p0_cmd_byte_addr <= {win_addr[ADDR_W-1:2], 2'b00};
        last_was_read        <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_ddr_port0_arbiter.sv
// Bench for ddr_port0_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_ddr_port0_arbiter;
  localparam logic [29:0] ADDR_LIMIT = 30'd5242880;
`ifdef ARB_STARVE_GUARD_EN
  localparam int MAX_WAIT = 64;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_calib_done = 1'b0;
  logic ready;
  logic last_was_read;

  ddr_port0_arbiter_if bus();

  ddr_port0_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .mem_calib_done (mem_calib_done),
    .bus            (bus),
    .ready          (ready),
    .last_was_read  (last_was_read)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model state: readiness, cooldown until the next decision may be made, round-robin owner
  bit          m_ready, m_lwr;
  bit [1:0]    m_hist;
  int          m_cool, m_starve;
  bit          e_wr_gnt, e_rd_gnt, e_wr_err, e_rd_err;
  logic [2:0]  e_instr;
  logic [29:0] e_addr;
  logic [5:0]  e_bl;

  // Observed command log
  int          g_cyc[$];
  bit          g_rd[$];
  logic [29:0] g_addr[$];
  int          n_en, n_wr_gnt, n_rd_gnt, n_wr_err, n_rd_err;
  logic [29:0] last_addr;
  logic [5:0]  last_bl;
  bit          drop_wr, drop_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit rd_w;
    bit force_wr;
    logic [29:0] a;
    logic [5:0] b;
    {e_wr_gnt, e_rd_gnt, e_wr_err, e_rd_err} = 4'b0;
    if (reset) begin
      m_ready = 0; m_lwr = 0; m_hist = 2'b00; m_cool = 0; m_starve = 0;
      return;
    end
    if (!m_ready) begin
      m_ready = m_hist[1];
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (bus.wr_req || bus.rd_req) begin
      force_wr = 0;
`ifdef ARB_STARVE_GUARD_EN
      force_wr = bus.wr_req && (m_starve >= MAX_WAIT);
`endif
      if (force_wr)                         rd_w = 0;
      else if (bus.rd_req && bus.rd_urgent) rd_w = 1;
      else if (bus.rd_req && bus.wr_req)    rd_w = !m_lwr;
      else                                  rd_w = bus.rd_req;
      if (rd_w && bus.wr_req && m_starve < 127) m_starve++;
      a = rd_w ? bus.rd_addr : bus.wr_addr;
      b = rd_w ? bus.rd_bl : bus.wr_bl;
      if (a >= ADDR_LIMIT) begin
        if (rd_w) e_rd_err = 1;
        else begin e_wr_err = 1; m_starve = 0; end
        m_cool = 1;
      end else if (!bus.p0_cmd_full) begin
        if (rd_w) e_rd_gnt = 1;
        else begin e_wr_gnt = 1; m_starve = 0; end
        e_instr = rd_w ? 3'b001 : 3'b000;
        e_addr  = a & ~30'd3;
        e_bl    = b;
        m_lwr   = rd_w;
        m_cool  = 2;
      end
    end
    m_hist = {m_hist[0], mem_calib_done};
  endtask

  task automatic compare();
    check("ready", ready, m_ready);
    check("last_was_read", last_was_read, m_lwr);
    check("wr_gnt", bus.wr_gnt, e_wr_gnt);
    check("rd_gnt", bus.rd_gnt, e_rd_gnt);
    check("wr_err", bus.wr_err, e_wr_err);
    check("rd_err", bus.rd_err, e_rd_err);
    check("cmd_en", bus.p0_cmd_en, e_wr_gnt | e_rd_gnt);
    if (e_wr_gnt || e_rd_gnt) begin
      check("cmd_instr", bus.p0_cmd_instr, e_instr);
      check("cmd_addr", bus.p0_cmd_byte_addr, e_addr);
      check("cmd_bl", bus.p0_cmd_bl, e_bl);
    end
  endtask

  task automatic log_outputs();
    if (bus.p0_cmd_en) begin
      n_en++;
      g_cyc.push_back(cyc);
      g_rd.push_back(bus.p0_cmd_instr == 3'b001);
      g_addr.push_back(bus.p0_cmd_byte_addr);
      last_addr = bus.p0_cmd_byte_addr;
      last_bl   = bus.p0_cmd_bl;
    end
    if (bus.wr_gnt) n_wr_gnt++;
    if (bus.rd_gnt) n_rd_gnt++;
    if (bus.wr_err) n_wr_err++;
    if (bus.rd_err) n_rd_err++;
  endtask

  // Per-cycle checker
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      compare();
      log_outputs();
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (drop_wr && (bus.wr_gnt || bus.wr_err)) bus.wr_req = 1'b0;
      if (drop_rd && (bus.rd_gnt || bus.rd_err)) bus.rd_req = 1'b0;
    end
  endtask

  function automatic logic [29:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      return ADDR_LIMIT + 30'($urandom_range(0, 1000));
    else if (r == 1) return ADDR_LIMIT - 30'($urandom_range(1, 4));
    else             return 30'($urandom_range(0, 32'(ADDR_LIMIT) - 1));
  endfunction

  initial begin
    int t0, base, b0, b1, b2;
    bit seen;
    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_bl = '0;
    bus.rd_req = 0; bus.rd_urgent = 0; bus.rd_addr = '0; bus.rd_bl = '0;
    bus.p0_cmd_full = 0;
    drop_wr = 0; drop_rd = 0;
    tick(3);
    check("reset_instr", bus.p0_cmd_instr, 3'b000);
    check("reset_cmd_en", bus.p0_cmd_en, 0);
    check("reset_ready", ready, 0);
    reset = 1'b0;

    // Calibration gating
    drop_wr = 1;
    bus.wr_addr = 30'h103; bus.wr_bl = 6'd5; bus.wr_req = 1;
    tick(50);
    check("calib_hold_no_cmd", n_en, 0);
    check("calib_hold_ready", ready, 0);
    mem_calib_done = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 10 && !ready; k++) tick(1);
    check("ready_latency", cyc - t0, 3);
    for (int k = 0; k < 10 && n_wr_gnt == 0; k++) tick(1);
    check("first_gnt_count", n_wr_gnt, 1);
    if (g_cyc.size() > 0) begin
      check("first_gnt_is_wr", g_rd[0], 0);
      check("first_gnt_addr", g_addr[0], 30'h100);
      check("first_gnt_after_ready", g_cyc[0] - (t0 + 3), 1);
    end
    tick(3);

    // Round-robin alternation with both held
    drop_wr = 0; drop_rd = 0;
    bus.wr_addr = 30'h100; bus.wr_bl = 6'd3;
    bus.rd_addr = 30'h2000; bus.rd_bl = 6'd3;
    base = g_cyc.size();
    bus.wr_req = 1; bus.rd_req = 1;
    tick(14);
    bus.wr_req = 0; bus.rd_req = 0;
    tick(3);
    check("alt_count", g_cyc.size() >= base + 4, 1);
    if (g_cyc.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check("alt_owner", g_rd[base+i], (i % 2) == 0);
        check("alt_addr", g_addr[base+i], (i % 2) == 0 ? 30'h2000 : 30'h100);
        if (i > 0) check("alt_spacing", g_cyc[base+i] - g_cyc[base+i-1], 3);
      end
    end

    // Urgent reads lock out writes
    b0 = n_wr_gnt; b1 = n_rd_gnt;
    bus.rd_urgent = 1; bus.wr_req = 1; bus.rd_req = 1;
    tick(30);
    check("urgent_no_wr", n_wr_gnt - b0, 0);
    check("urgent_rd_count", (n_rd_gnt - b1) >= 9, 1);
`ifdef ARB_STARVE_GUARD_EN
    b0 = n_wr_gnt;
    tick(3 * MAX_WAIT + 30);
    check("starve_guard_wr", (n_wr_gnt - b0) >= 1, 1);
`endif
    bus.wr_req = 0; bus.rd_req = 0; bus.rd_urgent = 0;
    tick(3);

    // Command FIFO full back-pressure
    drop_wr = 1; drop_rd = 1;
    bus.p0_cmd_full = 1;
    bus.wr_addr = 30'h40; bus.wr_bl = 6'd7; bus.wr_req = 1;
    b0 = n_en;
    tick(10);
    check("full_no_cmd", n_en - b0, 0);
    bus.p0_cmd_full = 0;
    b0 = n_wr_gnt;
    tick(8);
    check("full_release_one_gnt", n_wr_gnt - b0, 1);
    check("full_release_addr", last_addr, 30'h40);
    check("full_release_bl", last_bl, 6'd7);

    // Address limit boundary and low-bit clearing
    b0 = n_wr_err; b1 = n_en;
    bus.wr_addr = ADDR_LIMIT; bus.wr_req = 1;
    tick(8);
    check("limit_err_once", n_wr_err - b0, 1);
    check("limit_no_cmd", n_en - b1, 0);
    bus.wr_addr = ADDR_LIMIT - 30'd1; bus.wr_req = 1;
    tick(8);
    check("below_limit_addr", last_addr, 30'h4FFFFC);
    bus.wr_addr = 30'h103; bus.wr_req = 1;
    tick(8);
    check("addr_low_bits", last_addr, 30'h100);
    b0 = n_rd_err; b1 = n_en; b2 = n_rd_gnt;
    bus.rd_addr = 30'h3FFFFFFF; bus.rd_req = 1;
    tick(6);
    check("rd_limit_err_once", n_rd_err - b0, 1);
    check("rd_limit_no_cmd", n_en - b1, 0);
    check("rd_limit_no_gnt", n_rd_gnt - b2, 0);

    // Reset while the strobe is high
    bus.wr_addr = 30'h200; bus.wr_req = 1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk);
      #2;
      seen = bus.p0_cmd_en;
    end
    check("issue_seen", seen, 1);
    reset = 1'b1;
    #1;
    check("async_reset_cmd_en", bus.p0_cmd_en, 0);
    check("async_reset_gnt", bus.wr_gnt, 0);
    check("async_reset_ready", ready, 0);
    @(negedge clk);
    bus.wr_req = 0;
    tick(2);
    reset = 1'b0;
    tick(6);
    check("ready_after_reset", ready, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      if (!bus.wr_req && $urandom_range(0, 3) == 0) begin
        bus.wr_req = 1; bus.wr_addr = rand_addr(); bus.wr_bl = 6'($urandom);
      end else if (bus.wr_req && $urandom_range(0, 40) == 0) begin
        bus.wr_req = 0;
      end else if (bus.wr_req && $urandom_range(0, 7) == 0) begin
        bus.wr_addr = rand_addr();
      end
      if (!bus.rd_req && $urandom_range(0, 3) == 0) begin
        bus.rd_req = 1; bus.rd_addr = rand_addr(); bus.rd_bl = 6'($urandom);
      end else if (bus.rd_req && $urandom_range(0, 40) == 0) begin
        bus.rd_req = 0;
      end else if (bus.rd_req && $urandom_range(0, 7) == 0) begin
        bus.rd_bl = 6'($urandom);
      end
      bus.rd_urgent   = ($urandom_range(0, 3) == 0);
      bus.p0_cmd_full = ($urandom_range(0, 4) == 0);
      mem_calib_done  = ($urandom_range(0, 50) != 0);
    end
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
